// File: rtl/floatpkg.sv
// Shared single-precision float format plus the constants, state encoding and
// small helpers used by the multi-cycle adder.
package floatpkg;

  typedef struct packed {
    logic        signal;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } float_t;

  localparam int EXP_MAX = 255;
  // Working significand: {hidden 1, fraction[22:0], G, R, S}
  localparam int SIG_W   = 27;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } fadd_state_t;

  // A zero exponent means the value is zero; drop any fraction bits so that
  // magnitude comparisons treat it as a true zero.
  function automatic float_t flush_zero(input float_t f);
    float_t r;
    r = f;
    if (f.exponent == 8'd0) begin
      r.fraction = '0;
    end
    return r;
  endfunction

  // Expand an operand into the working significand with empty guard bits.
  function automatic logic [SIG_W-1:0] to_sig(input float_t f);
    if (f.exponent == 8'd0) begin
      return '0;
    end
    return {1'b1, f.fraction, 3'b000};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized working significand, including the
// renormalization carry and saturation to infinity.
module fp_round_rne
  import floatpkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic [9:0]       exp_in,
  output logic [22:0]      frac_out,
  output logic [7:0]       exp_out,
  output logic             overflow
);

  logic        guard_bit;
  logic        rest_bits;
  logic        round_up;
  logic [24:0] mant;
  logic [9:0]  exp_adj;

  // Decide the increment from G and R|S, then fold a mantissa carry into the exponent.
  always_comb begin
    guard_bit = sig[2];
    rest_bits = sig[1] | sig[0];
    round_up  = guard_bit & (rest_bits | sig[3]);
    mant      = {1'b0, sig[26:3]} + {24'd0, round_up};
    exp_adj   = exp_in + {9'd0, mant[24]};
    frac_out  = mant[24] ? mant[23:1] : mant[22:0];
    exp_out   = exp_adj[7:0];
    overflow  = 1'b0;
    if (exp_adj >= 10'(EXP_MAX)) begin
      frac_out = '0;
      exp_out  = 8'hFF;
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle float adder: accepts one operand pair, aligns the smaller one a
// single bit per cycle, adds, normalizes, rounds, then holds the result until
// the consumer takes it.
module fp_add_seq
  import floatpkg::*;
#(
  parameter int ALIGN_MAX = 26
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  float_t a,
  input  float_t b,
  output logic   out_valid,
  input  logic   out_ready,
  output float_t result,
  output logic   overflow,
  output logic   busy
);

  localparam logic [7:0] ALIGN_CAP = 8'(ALIGN_MAX);

  fadd_state_t      state;
  logic [SIG_W-1:0] big_sig;
  logic [SIG_W-1:0] small_sig;
  logic [SIG_W:0]   sum;
  logic [9:0]       work_exp;
  logic [7:0]       cnt;
  logic             res_sign;
  logic             eff_sub;
  logic             special;

  float_t           fa;
  float_t           fb;
  float_t           big_f;
  float_t           small_f;
  logic             a_big;
  logic [7:0]       exp_diff;
  logic             far;
  logic [SIG_W-1:0] small_init;
  logic [7:0]       cnt_init;

  logic [22:0]      rnd_frac;
  logic [7:0]       rnd_exp;
  logic             rnd_ovf;

  // Order the incoming operands by magnitude and prepare the alignment work.
  always_comb begin
    fa         = flush_zero(a);
    fb         = flush_zero(b);
    a_big      = {fa.exponent, fa.fraction} >= {fb.exponent, fb.fraction};
    big_f      = a_big ? fa : fb;
    small_f    = a_big ? fb : fa;
    exp_diff   = big_f.exponent - small_f.exponent;
    far        = exp_diff > ALIGN_CAP;
    small_init = to_sig(small_f);
    if (far) begin
      small_init = {{(SIG_W-1){1'b0}}, |small_init};
    end
    cnt_init   = far ? ALIGN_CAP : exp_diff;
  end

  fp_round_rne u_round (
    .sig      (sum[SIG_W-1:0]),
    .exp_in   (work_exp),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .overflow (rnd_ovf)
  );

  // Sequencer: accept, align, add, normalize, round, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      big_sig   <= '0;
      small_sig <= '0;
      sum       <= '0;
      work_exp  <= '0;
      cnt       <= '0;
      res_sign  <= 1'b0;
      eff_sub   <= 1'b0;
      special   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            big_sig   <= to_sig(big_f);
            small_sig <= small_init;
            work_exp  <= {2'b00, big_f.exponent};
            cnt       <= cnt_init;
            res_sign  <= big_f.signal;
            eff_sub   <= big_f.signal ^ small_f.signal;
            special   <= (a.exponent == 8'hFF) || (b.exponent == 8'hFF);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ALIGN;
          end
        end
        ALIGN: begin
          if (special) begin
            result    <= {res_sign, 8'hFF, 23'd0};
            overflow  <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt != 8'd0) begin
            small_sig <= {1'b0, small_sig[SIG_W-1:2], small_sig[1] | small_sig[0]};
            cnt       <= cnt - 8'd1;
          end else begin
            state <= ADD;
          end
        end
        ADD: begin
          if (eff_sub) begin
            sum <= {1'b0, big_sig} - {1'b0, small_sig};
          end else begin
            sum <= {1'b0, big_sig} + {1'b0, small_sig};
          end
          state <= NORM;
        end
        NORM: begin
          if (sum == '0) begin
            res_sign <= 1'b0;
            work_exp <= '0;
            state    <= ROUND;
          end else if (sum[SIG_W]) begin
            sum      <= {1'b0, sum[SIG_W:2], sum[1] | sum[0]};
            work_exp <= work_exp + 10'd1;
          end else if (!sum[SIG_W-1] && (work_exp > 10'd1)) begin
            sum      <= {sum[SIG_W-1:0], 1'b0};
            work_exp <= work_exp - 10'd1;
          end else if (!sum[SIG_W-1]) begin
            sum      <= '0;
            work_exp <= '0;
            state    <= ROUND;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          result    <= {res_sign, rnd_exp, rnd_frac};
          overflow  <= rnd_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: the driver queues hand-computed results at
// each accept, and an independent monitor checks every result the DUT presents.
module tb_fp_add_seq;
  import floatpkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   out_ready = 1'b1;
  float_t a = '0;
  float_t b = '0;
  logic   in_ready;
  logic   out_valid;
  float_t result;
  logic   overflow;
  logic   busy;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
    int          stamp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  int   cycle = 0;
  logic seen_valid = 1'b0;

  fp_add_seq #(.ALIGN_MAX(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle stamp used to measure accept-to-result latency.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic flag_timeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Monitor: pop the oldest expectation each time out_valid rises.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_valid = 1'b0;
    end else begin
      if (out_valid && !seen_valid) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_result: actual=%h required=none", result);
        end else begin
          mon_e = sb.pop_front();
          check_output({mon_e.name, "_result"}, result, mon_e.res);
          check_output({mon_e.name, "_overflow"}, {31'd0, overflow}, {31'd0, mon_e.ovf});
          check_output({mon_e.name, "_latency"}, 32'(cycle - mon_e.stamp), 32'(mon_e.lat));
        end
      end
      seen_valid = out_valid;
    end
  end

  task automatic apply_stimulus(input string name, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] res, input logic ovf, input int lat, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      flag_timeout({name, "_accept"});
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      sb.push_back('{res: res, ovf: ovf, lat: lat, stamp: cycle + 1, name: name});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) flag_timeout({name, "_idle"});
  endtask

  task automatic run_vec(input string name, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] res, input logic ovf, input int lat);
    apply_stimulus(name, av, bv, res, ovf, lat, 1'b1);
    wait_idle(name);
  endtask

  // Stimulus sequence.
  initial begin
    int waited;
    int stable_bad;

    repeat (3) @(negedge clk);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_result", result, 32'd0);
    check_output("reset_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    run_vec("one_plus_one",    32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 5);
    run_vec("one_minus_one",   32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 4);
    run_vec("tie_even_down",   32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 28);
    run_vec("tie_even_up",     32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 28);
    run_vec("ovf_max",         32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 5);
    run_vec("inf_input",       32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1);
    run_vec("three_minus_one", 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 5);
    run_vec("norm_left",       32'h3F800000, 32'hBF400000, 32'h3E800000, 1'b0, 7);
    run_vec("zero_plus_pi",    32'h00000000, 32'h40490FDB, 32'h40490FDB, 1'b0, 30);
    run_vec("neg_sum",         32'hC0000000, 32'hBF800000, 32'hC0400000, 1'b0, 5);

    // Backpressure: the held result must stay put and a second request must wait.
    out_ready = 1'b0;
    apply_stimulus("bp_first", 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 5, 1'b1);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) flag_timeout("bp_first_valid");
    @(negedge clk);
    a = 32'hC0000000;
    b = 32'hBF800000;
    in_valid = 1'b1;
    stable_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (result !== 32'h40000000 || in_ready !== 1'b0 || out_valid !== 1'b1) stable_bad++;
    end
    check_output("bp_hold_stable", 32'(stable_bad), 32'd0);
    check_output("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    apply_stimulus("bp_second", 32'hC0000000, 32'hBF800000, 32'hC0400000, 1'b0, 5, 1'b1);
    wait_idle("bp_second");

    // Reset while aligning: the transaction is dropped and outputs return to reset values.
    apply_stimulus("rst_pair", 32'h4B000000, 32'h3F800000, 32'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check_output("rst_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_reset", 32'h4B000000, 32'h3F800000, 32'h4B000001, 1'b0, 27);

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) flag_timeout("scoreboard_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global bound so a stuck handshake can never hang the run.
  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
